// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register and next-PC selector for the 5-stage MIPS pipeline (delayed branches).
// Optional branch performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_pc_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic [31:0] Instr_D,
    input  logic [31:0] PC4_D,
    input  logic        Cmp_Equal,
    input  logic [31:0] Rs_Fwd_D,
    output logic [31:0] PC_F,
    output logic [31:0] PC4_F,
    output logic        Redirect_F
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] Br_Cnt,
    output logic [31:0] Br_Taken_Cnt
`endif
);

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] FN_JR     = 6'b001000;
    localparam logic [5:0] FN_JALR   = 6'b001001;

    logic [31:0] pc_q, pc_d;
    logic        redirect_q, redirect_d;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic        is_beq, is_bne, is_branch, is_jump, is_jreg, br_taken;
    logic [31:0] br_target, j_target;

    assign op    = Instr_D[31:26];
    assign funct = Instr_D[5:0];

    always_comb begin
        is_beq    = (op == OP_BEQ);
        is_bne    = (op == OP_BNE);
        is_branch = is_beq || is_bne;
        is_jump   = (op == OP_J) || (op == OP_JAL);
        is_jreg   = (op == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));
        br_taken  = (is_beq && Cmp_Equal) || (is_bne && !Cmp_Equal);
    end

    assign br_target = PC4_D + {{14{Instr_D[15]}}, Instr_D[15:0], 2'b00};
    assign j_target  = {PC4_D[31:28], Instr_D[25:0], 2'b00};

    // A stalled ID instruction is re-evaluated next cycle, so its decision is dropped here.
    always_comb begin
        pc_d       = pc_q + 32'd4;
        redirect_d = 1'b0;
        if (Stall) begin
            pc_d       = pc_q;
            redirect_d = redirect_q;
        end else if (is_jreg) begin
            pc_d       = Rs_Fwd_D;
            redirect_d = 1'b1;
        end else if (is_jump) begin
            pc_d       = j_target;
            redirect_d = 1'b1;
        end else if (br_taken) begin
            pc_d       = br_target;
            redirect_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= PC_RESET;
            redirect_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
        end
    end

    assign PC_F       = pc_q;
    assign PC4_F      = pc_q + 32'd4;
    assign Redirect_F = redirect_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] br_taken_cnt_q, br_taken_cnt_d;

    always_comb begin
        br_cnt_d       = br_cnt_q;
        br_taken_cnt_d = br_taken_cnt_q;
        if (!Stall && is_branch) begin
            br_cnt_d = br_cnt_q + 32'd1;
            if (br_taken) begin
                br_taken_cnt_d = br_taken_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            br_cnt_q       <= 32'd0;
            br_taken_cnt_q <= 32'd0;
        end else begin
            br_cnt_q       <= br_cnt_d;
            br_taken_cnt_q <= br_taken_cnt_d;
        end
    end

    assign Br_Cnt       = br_cnt_q;
    assign Br_Taken_Cnt = br_taken_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: a default-reset DUT plus a wrap-around DUT with PC_RESET=0xFFFFFFFC.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_pc_unit;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] instr_d = 32'd0;
  logic [31:0] pc4_d = 32'd0;
  logic        cmp_eq = 1'b0;
  logic [31:0] rs_fwd = 32'd0;

  logic [31:0] pc_f_a, pc4_f_a, pc_f_b, pc4_f_b;
  logic        redir_a, redir_b;

  always #5 clk = ~clk;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] br_cnt_a, br_tk_a, br_cnt_b, br_tk_b;
`endif

  fetch_pc_unit dut_a (
    .clk        (clk),
    .reset      (rst_n),
    .Stall      (stall),
    .Instr_D    (instr_d),
    .PC4_D      (pc4_d),
    .Cmp_Equal  (cmp_eq),
    .Rs_Fwd_D   (rs_fwd),
    .PC_F       (pc_f_a),
    .PC4_F      (pc4_f_a),
    .Redirect_F (redir_a)
`ifdef FETCH_PERF_CNT_EN
    ,
    .Br_Cnt       (br_cnt_a),
    .Br_Taken_Cnt (br_tk_a)
`endif
  );

  fetch_pc_unit #(.PC_RESET(32'hFFFF_FFFC)) dut_b (
    .clk        (clk),
    .reset      (rst_n),
    .Stall      (stall),
    .Instr_D    (instr_d),
    .PC4_D      (pc4_d),
    .Cmp_Equal  (cmp_eq),
    .Rs_Fwd_D   (rs_fwd),
    .PC_F       (pc_f_b),
    .PC4_F      (pc4_f_b),
    .Redirect_F (redir_b)
`ifdef FETCH_PERF_CNT_EN
    ,
    .Br_Cnt       (br_cnt_b),
    .Br_Taken_Cnt (br_tk_b)
`endif
  );

  // ---------------- scoreboard ----------------
  // entry = {sel[1:0], a[31:0], b[31:0]}
  //   sel 0: dut_a  a=PC_F b[0]=Redirect_F ; sel 1: dut_b same ; sel 2: dut_a counters a=Br_Cnt b=Br_Taken_Cnt
  logic [65:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          failures = 0;

  task automatic push_exp(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input string nm);
    exp_q.push_back({sel, a, b});
    name_q.push_back(nm);
  endtask

  // Monitor: at each falling edge, compare every expectation posted since the last rising edge.
  always @(negedge clk) begin
    logic [65:0] e;
    string       nm;
    logic [31:0] act_pc, act_pc4;
    logic        act_r;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e[65:64] == 2'd2) begin
`ifdef FETCH_PERF_CNT_EN
        checks = checks + 2;
        if (br_cnt_a !== e[63:32]) begin
          failures = failures + 1;
          $display("FAIL %s Br_Cnt got=%h exp=%h", nm, br_cnt_a, e[63:32]);
        end
        if (br_tk_a !== e[31:0]) begin
          failures = failures + 1;
          $display("FAIL %s Br_Taken_Cnt got=%h exp=%h", nm, br_tk_a, e[31:0]);
        end
`endif
      end else begin
        act_pc  = (e[65:64] == 2'd0) ? pc_f_a  : pc_f_b;
        act_pc4 = (e[65:64] == 2'd0) ? pc4_f_a : pc4_f_b;
        act_r   = (e[65:64] == 2'd0) ? redir_a : redir_b;
        checks  = checks + 3;
        if (act_pc !== e[63:32]) begin
          failures = failures + 1;
          $display("FAIL %s PC_F got=%h exp=%h", nm, act_pc, e[63:32]);
        end
        if (act_pc4 !== (e[63:32] + 32'd4)) begin
          failures = failures + 1;
          $display("FAIL %s PC4_F got=%h exp=%h", nm, act_pc4, e[63:32] + 32'd4);
        end
        if (act_r !== e[0]) begin
          failures = failures + 1;
          $display("FAIL %s Redirect_F got=%b exp=%b", nm, act_r, e[0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Apply inputs, take one rising edge, then post the expected dut_a state after that edge.
  task automatic step(input logic rst, input logic stl, input logic [31:0] ins,
                      input logic [31:0] p4, input logic cmp, input logic [31:0] rs,
                      input logic [31:0] exp_pc, input logic exp_r, input string nm);
    rst_n   = rst;
    stall   = stl;
    instr_d = ins;
    pc4_d   = p4;
    cmp_eq  = cmp;
    rs_fwd  = rs;
    @(posedge clk);
    #1;
    push_exp(2'd0, exp_pc, {31'd0, exp_r}, nm);
  endtask

  initial begin
    // reset for two edges; wrap DUT sits at its own reset value
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0000_3000, 1'b0, "reset_e1");
    push_exp(2'd1, 32'hFFFF_FFFC, 32'd0, "wrap_reset");
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0000_3000, 1'b0, "reset_e2");
`ifdef FETCH_PERF_CNT_EN
    push_exp(2'd2, 32'd0, 32'd0, "cnt_reset");
`endif
    // sequential fetch; dut_b wraps 0xFFFFFFFC -> 0
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0000_3004, 1'b0, "seq_1");
    push_exp(2'd1, 32'h0000_0000, 32'd0, "wrap_seq");
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0000_3008, 1'b0, "seq_2");
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0000_300C, 1'b0, "seq_3");
    // beq backward taken / not taken
    step(1'b1, 1'b0, 32'h1000_FFFE, 32'h0000_3008, 1'b1, 32'h0, 32'h0000_3000, 1'b1, "beq_taken");
    step(1'b1, 1'b0, 32'h1000_FFFE, 32'h0000_3008, 1'b0, 32'h0, 32'h0000_3004, 1'b0, "beq_not_taken");
    // bne taken / not taken
    step(1'b1, 1'b0, 32'h1400_0003, 32'h0000_3010, 1'b0, 32'h0, 32'h0000_301C, 1'b1, "bne_taken");
    step(1'b1, 1'b0, 32'h1400_0003, 32'h0000_3010, 1'b1, 32'h0, 32'h0000_3020, 1'b0, "bne_not_taken");
    // j
    step(1'b1, 1'b0, 32'h0800_0C10, 32'h0000_3004, 1'b0, 32'h0, 32'h0000_3040, 1'b1, "j");
    // jr under stall holds PC and Redirect_F, then redirects
    step(1'b1, 1'b1, 32'h03E0_0008, 32'h0, 1'b0, 32'h0000_3100, 32'h0000_3040, 1'b1, "jr_stall_1");
    step(1'b1, 1'b1, 32'h03E0_0008, 32'h0, 1'b0, 32'h0000_3100, 32'h0000_3040, 1'b1, "jr_stall_2");
    step(1'b1, 1'b0, 32'h03E0_0008, 32'h0, 1'b0, 32'h0000_3100, 32'h0000_3100, 1'b1, "jr_go");
    // jalr with misaligned target is loaded as given
    step(1'b1, 1'b0, 32'h03E0_F809, 32'h0, 1'b1, 32'h0000_3102, 32'h0000_3102, 1'b1, "jalr_misaligned");
    // R-type add and a non-R op with funct=001000 are sequential
    step(1'b1, 1'b0, 32'h0022_0820, 32'h0, 1'b0, 32'h0000_9999, 32'h0000_3106, 1'b0, "add_seq");
    step(1'b1, 1'b0, 32'h0400_0008, 32'h0, 1'b1, 32'h0000_9999, 32'h0000_310A, 1'b0, "op1_funct8_seq");
    // jal keeps PC4_D upper nibble
    step(1'b1, 1'b0, 32'h0C00_0100, 32'hA000_0000, 1'b0, 32'h0, 32'hA000_0400, 1'b1, "jal_region");
    // stall beats a taken beq, then the beq is taken
    step(1'b1, 1'b1, 32'h1000_0004, 32'h0000_3010, 1'b1, 32'h0, 32'hA000_0400, 1'b1, "beq_stalled");
    step(1'b1, 1'b0, 32'h1000_0004, 32'h0000_3010, 1'b1, 32'h0, 32'h0000_3020, 1'b1, "beq_after_stall");
    // reset beats a taken beq; first edge after reset follows normal priority
    step(1'b0, 1'b0, 32'h1000_0004, 32'h0000_3010, 1'b1, 32'h0, 32'h0000_3000, 1'b0, "reset_vs_beq");
    step(1'b1, 1'b0, 32'h1000_0004, 32'h0000_3010, 1'b1, 32'h0, 32'h0000_3020, 1'b1, "beq_after_reset");
    step(1'b1, 1'b1, 32'h0000_0000, 32'h0, 1'b0, 32'h0, 32'h0000_3020, 1'b1, "stall_holds_redirect");
    step(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0, 32'h0000_3024, 1'b0, "seq_clears_redirect");
    // counter stream: beq taken, bne not taken, beq stalled 3 cycles then taken
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0000_3000, 1'b0, "cnt_stream_reset");
    step(1'b1, 1'b0, 32'h1000_0004, 32'h0000_3004, 1'b1, 32'h0, 32'h0000_3014, 1'b1, "cnt_beq_taken");
    step(1'b1, 1'b0, 32'h1400_0002, 32'h0000_3018, 1'b1, 32'h0, 32'h0000_3018, 1'b0, "cnt_bne_not_taken");
    step(1'b1, 1'b1, 32'h1000_0001, 32'h0000_301C, 1'b1, 32'h0, 32'h0000_3018, 1'b0, "cnt_beq_stall_1");
    step(1'b1, 1'b1, 32'h1000_0001, 32'h0000_301C, 1'b1, 32'h0, 32'h0000_3018, 1'b0, "cnt_beq_stall_2");
    step(1'b1, 1'b1, 32'h1000_0001, 32'h0000_301C, 1'b1, 32'h0, 32'h0000_3018, 1'b0, "cnt_beq_stall_3");
    step(1'b1, 1'b0, 32'h1000_0001, 32'h0000_301C, 1'b1, 32'h0, 32'h0000_3020, 1'b1, "cnt_beq_taken_2");
`ifdef FETCH_PERF_CNT_EN
    push_exp(2'd2, 32'd3, 32'd2, "cnt_final");
`endif
    // ---------------- final report ----------------
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
      $fatal(1, "scoreboard not drained");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage program-counter register and next-PC selector for the 5-stage MIPS pipeline.
- Consumes the ID-stage branch-compare result, the ID instruction, its PC+4 and the forwarded rs value.
- Produces the fetch PC for instruction memory and PC+4 for the IF/ID register.
- Architectural branch delay slot: the instruction already in IF is never flushed.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- Stall  input  1  hazard-unit stall; 1 = hold PC
- Instr_D  input  32  instruction currently in ID
- PC4_D  input  32  PC+4 of the ID instruction
- Cmp_Equal  input  1  ID comparator result, 1 = rs equals rt
- Rs_Fwd_D  input  32  forwarded rs value, used by jr/jalr
- PC_F  output  32  fetch address to instruction memory
- PC4_F  output  32  PC_F + 4, combinational
- Redirect_F  output  1  registered; 1 = current PC_F came from a non-sequential update

Behaviour:
- Reset: on a clk edge with reset=0, PC_F <= PC_RESET and Redirect_F <= 0. Reset has priority over everything, including mid-stall and mid-redirect.
- Decode from Instr_D:
  - beq: op 000100.
  - bne: op 000101.
  - j: op 000010.
  - jal: op 000011.
  - jr: op 000000 with funct 001000.
  - jalr: op 000000 with funct 001001.
  - Any other encoding is sequential.
- Targets:
  - Branch: PC4_D + (sign-extended Instr_D[15:0] << 2).
  - Jump: {PC4_D[31:28], Instr_D[25:0], 2'b00}.
  - Register jump: Rs_Fwd_D, used unmodified.
- Taken conditions:
  - beq is taken when Cmp_Equal=1.
  - bne is taken when Cmp_Equal=0.
  - Cmp_Equal is ignored for every other opcode.
- Next-PC priority, evaluated each edge with reset=1:
  1. Stall=1: PC_F holds and Redirect_F holds. Any ID decision is discarded because the ID instruction is re-evaluated next cycle.
  2. jr/jalr: next PC = Rs_Fwd_D.
  3. j/jal: next PC = jump target.
  4. Taken beq/bne: next PC = branch target.
  5. Otherwise: next PC = PC_F + 4.
- Redirect_F <= 1 for cases 2–4 and <= 0 for case 5.
- Latency: the redirect takes effect one edge after the branch is in ID. The instruction fetched in that same cycle (the delay slot) proceeds normally.
- Arithmetic: all additions are 32-bit modulo 2^32, with no overflow detection.
  - PC_F = 32'hFFFF_FFFC sequential → 32'h0000_0000.
- No alignment enforcement: a misaligned jr target is loaded as given.
- Simultaneous Stall=1 and taken branch: the stall wins; the branch is taken on the first non-stalled edge, provided the ID instruction is still present.
- Reset deasserted while a branch sits in ID: that first edge after reset follows the normal priority rules.

Optional Feature:
- Macro name: FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs Br_Cnt [31:0] and Br_Taken_Cnt [31:0], both reset to 0.
  - On each non-stalled edge with beq/bne in ID, Br_Cnt increments by 1.
  - Br_Taken_Cnt increments as well when that branch is taken.
  - Both counters wrap at 2^32.
  - Stalled cycles never count, so a branch held by a stall is counted exactly once.
- When undefined:
  - The ports and registers are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: reset=0 for 2 edges, then reset=1, Instr_D=0, no stall → PC_F=0x3000, Redirect_F=0; after 3 edges PC_F=0x300C; PC4_F=0x3010.
- beq backward: Instr_D=0x1000FFFE, PC4_D=0x3008, Cmp_Equal=1 → next PC_F=0x3000, Redirect_F=1. Same case with Cmp_Equal=0 → PC_F+4, Redirect_F=0.
- bne / j:
  - bne: Instr_D=0x14000003, PC4_D=0x3010, Cmp_Equal=0 → PC_F=0x301C.
  - j: Instr_D=0x08000C10, PC4_D=0x3004 → PC_F=0x3040.
- Stall with jr: Instr_D=0x03E00008, Rs_Fwd_D=0x3100, Stall=1 for 2 edges → PC_F unchanged. Stall=0 → PC_F=0x3100.
- Wrap and reset mid-redirect:
  - With PC_RESET=0xFFFFFFFC, sequential → PC_F=0x00000000.
  - Asserting reset on the same edge as a taken beq → PC_F=PC_RESET, Redirect_F=0.
- FETCH_PERF_CNT_EN counters: feed a stream beq taken, bne not taken, beq held 3 stalled cycles then taken → Br_Cnt=3, Br_Taken_Cnt=2.
